// File: rtl/serial_operand_feeder_if.sv
// Operand handshake and serial bit bus for the bit-serial adder feeder.
// master: operand source / bit sink; slave: serial_operand_feeder.
interface serial_operand_feeder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             x;
  logic             y;
  logic             bit_valid;
  logic             bit_first;
  logic             bit_last;
  logic             busy;

  modport master (
    output in_valid, a, b,
    input  in_ready, x, y,
    input  bit_valid, bit_first, bit_last, busy
  );

  modport slave (
    input  in_valid, a, b,
    output in_ready, x, y,
    output bit_valid, bit_first, bit_last, busy
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// Loads an operand pair on handshake, shifts it out LSB-first on x/y,
// then drives one flush cycle (x=y=0) so the adder emits its carry-out.
// Ports: clk, rst (async, active-high), bus (slave modport).
module serial_operand_feeder #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  serial_operand_feeder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CW-1:0]    cnt_q;
  logic             x_q;
  logic             y_q;
  logic             vld_q;
  logic             first_q;
  logic             last_q;
  logic             ready;
  logic             hs;

  assign ready = (state_q == IDLE) || (state_q == FLUSH);
  assign hs    = bus.in_valid && ready;

  // cnt_q is the index of the bit currently on x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, FLUSH: begin
          if (hs) begin
            state_q <= SHIFT;
            x_q     <= bus.a[0];
            y_q     <= bus.b[0];
            sa_q    <= bus.a >> 1;
            sb_q    <= bus.b >> 1;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        SHIFT: begin
          first_q <= 1'b0;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FLUSH;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            last_q  <= 1'b1;
          end else begin
            x_q   <= sa_q[0];
            y_q   <= sb_q[0];
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          x_q     <= 1'b0;
          y_q     <= 1'b0;
          vld_q   <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.bit_valid = vld_q;
  assign bus.bit_first = first_q;
  assign bus.bit_last  = last_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder with a bit-serial adder model
// that deserializes z and checks each word against its expected sum.
module tb_serial_operand_feeder;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_operand_feeder_if #(.WIDTH(W)) bus ();

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial adder model sharing rst with the feeder.
  logic c_q;
  logic z;
  assign z = bus.x ^ bus.y ^ c_q;
  always @(posedge clk or posedge rst) begin
    if (rst) c_q <= 1'b0;
    else if (bus.bit_valid)
      c_q <= (bus.x & bus.y) | (bus.x & c_q) | (bus.y & c_q);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t         exp_q[$];
  vec_t         e;
  int           idx;
  int           cyc;
  int           last_cyc;
  int           first_gap;
  bit           post;
  bit           bad;
  logic [W-1:0] xw;
  logic [W-1:0] yw;
  logic [W:0]   zw;

  initial begin
    idx = 0; cyc = 0; last_cyc = -100; first_gap = 0;
    post = 0; bad = 0; xw = '0; yw = '0; zw = '0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      idx  = 0;
      post = 0;
      bad  = 0;
    end else begin
      if (post && !bus.bit_valid) chk("carry_clear", 32'(z), 0);
      post = 0;
      if (bus.bit_valid && !bus.bit_last) begin
        if (bus.bit_first) first_gap = cyc - last_cyc;
        if (bus.bit_first != (idx == 0)) bad = 1;
        if (idx < W) begin
          xw[idx] = bus.x;
          yw[idx] = bus.y;
          zw[idx] = z;
        end
        idx++;
      end else if (bus.bit_last) begin
        if (bus.bit_first || !bus.bit_valid) bad = 1;
        if (bus.x || bus.y) bad = 1;
        zw[W]    = z;
        last_cyc = cyc;
        post     = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("x_bits", 32'(xw), 32'(e.a));
          chk("y_bits", 32'(yw), 32'(e.b));
          chk("sum", 32'(zw), 32'(e.s));
          chk("nbits", 32'(idx + 1), 32'(W + 1));
          chk("flags", 32'(bad), 0);
        end
        idx = 0;
        bad = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W:0] s);
    int n;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    else exp_q.push_back('{av, bv, s});
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    logic [W:0]   pat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    checks = 0;
    errors = 0;
    tbl[0] = '{8'h5A, 8'h00, 9'h05A};
    tbl[1] = '{8'hFF, 8'h01, 9'h100};
    tbl[2] = '{8'h03, 8'h01, 9'h004};
    tbl[3] = '{8'h10, 8'h20, 9'h030};
    tbl[4] = '{8'hFF, 8'hFF, 9'h1FE};
    tbl[5] = '{8'h80, 8'h80, 9'h100};
    tbl[6] = '{8'h00, 8'h00, 9'h000};
    tbl[7] = '{8'hA5, 8'h5A, 9'h0FF};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_valid", 32'(bus.bit_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);

    // One word, cycle by cycle.
    pat          = 9'h05A;
    bus.a        = 8'h5A;
    bus.b        = 8'h00;
    bus.in_valid = 1'b1;
    exp_q.push_back('{8'h5A, 8'h00, 9'h05A});
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      chk($sformatf("seq_x_%0d", k), 32'(bus.x), 32'(pat[k-1]));
      chk($sformatf("seq_vld_%0d", k), 32'(bus.bit_valid), 1);
      chk($sformatf("seq_first_%0d", k), 32'(bus.bit_first),
          32'(k == 1));
      chk($sformatf("seq_last_%0d", k), 32'(bus.bit_last),
          32'(k == W + 1));
      chk($sformatf("seq_rdy_%0d", k), 32'(bus.in_ready),
          32'(k == W + 1));
    end
    drain();

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].s);
      bus.in_valid = 1'b0;
      drain();
    end

    // Back-to-back words.
    send(8'h03, 8'h01, 9'h004);
    send(8'h10, 8'h20, 9'h030);
    bus.in_valid = 1'b0;
    drain();
    chk("b2b_gap", 32'(first_gap), 1);

    // Operand changes during SHIFT are ignored.
    send(8'h3C, 8'hC3, 9'h0FF);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    chk("busy_no_ready", 32'(n), 32'(W));
    drain();

    // Reset in the middle of a word.
    send(8'hC7, 8'h39, 9'h100);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_x", 32'(bus.x), 0);
    chk("mid_rst_y", 32'(bus.y), 0);
    chk("mid_rst_valid", 32'(bus.bit_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_z", 32'(z), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h81, 8'h7F, 9'h100);
    bus.in_valid = 1'b0;
    drain();

    // Random words with random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ra, rb, {1'b0, ra} + {1'b0, rb});
      n = $urandom_range(0, 2);
      if (n > 0) begin
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
